// File: rtl/mem_responder_if.sv
// Command/response bus between a requester and mem_responder.
// Latency: none (wires only).
// Backpressure: none; the responder accepts one command per cycle when idle.
// Ports: mem_cmd/mem_addr/write_data (requester -> responder),
//        read_data/read_valid (responder -> requester).
interface mem_responder_if;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        read_valid;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, read_valid
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, read_valid
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-mapped responder: 256x16 RAM, LED register and synchronized switch port.
// Latency: READ sampled at edge N returns read_data/read_valid from edge N (one cycle).
// Backpressure: none; commands are ignored while busy (post-reset RAM clear, 256 cycles).
// Ports: clk, reset (async active-high); bus (slave modport: mem_cmd, mem_addr,
//        write_data, read_data, read_valid); busy, bad_access (sticky), SW in, LEDR out.
module mem_responder (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus,
  output logic             busy,
  output logic             bad_access,
  input  logic [7:0]       SW,
  output logic [7:0]       LEDR
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;

  localparam logic [8:0] ADDR_LED = 9'h100;
  localparam logic [8:0] ADDR_SW  = 9'h140;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  clr_idx, clr_idx_nxt;
  logic [7:0]  sw_s1, sw_s2;
  logic [15:0] ram [256];

  logic        ram_we;
  logic [7:0]  ram_waddr;
  logic [15:0] ram_wdata;
  logic        led_we;
  logic        rd_en;
  logic [15:0] rd_mux;
  logic        err;

  logic        is_ram;
  assign is_ram = (bus.mem_addr[8] == 1'b0);

  assign busy = (state == CLEAR);

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    ram_we      = 1'b0;
    ram_waddr   = bus.mem_addr[7:0];
    ram_wdata   = bus.write_data;
    led_we      = 1'b0;
    rd_en       = 1'b0;
    err         = 1'b0;
    rd_mux      = 16'h0000;

    // Read source mux; unmapped addresses read as zero.
    if (is_ram)
      rd_mux = ram[bus.mem_addr[7:0]];
    else if (bus.mem_addr == ADDR_LED)
      rd_mux = {8'h00, LEDR};
    else if (bus.mem_addr == ADDR_SW)
      rd_mux = {8'h00, sw_s2};

    case (state)
      CLEAR: begin
        // Commands are ignored entirely here; only the zeroing write happens.
        ram_we      = 1'b1;
        ram_waddr   = clr_idx;
        ram_wdata   = 16'h0000;
        clr_idx_nxt = clr_idx + 8'd1;
        if (clr_idx == 8'hFF)
          state_nxt = IDLE;
      end
      IDLE: begin
        case (bus.mem_cmd)
          CMD_READ: begin
            rd_en = 1'b1;
            if (!is_ram && bus.mem_addr != ADDR_LED && bus.mem_addr != ADDR_SW)
              err = 1'b1;
          end
          CMD_WRITE: begin
            if (is_ram)
              ram_we = 1'b1;
            else if (bus.mem_addr == ADDR_LED)
              led_we = 1'b1;
            else
              err = 1'b1;  // switch port is read-only; everything else unmapped
          end
          CMD_RSVD: err = 1'b1;
          CMD_NONE: ;
          default:  ;
        endcase
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= CLEAR;
      clr_idx        <= 8'h00;
      sw_s1          <= 8'h00;
      sw_s2          <= 8'h00;
      LEDR           <= 8'h00;
      bad_access     <= 1'b0;
      bus.read_data  <= 16'h0000;
      bus.read_valid <= 1'b0;
    end else begin
      state          <= state_nxt;
      clr_idx        <= clr_idx_nxt;
      sw_s1          <= SW;
      sw_s2          <= sw_s1;
      bus.read_valid <= rd_en;
      if (rd_en)
        bus.read_data <= rd_mux;
      if (led_we)
        LEDR <= bus.write_data[7:0];
      if (err)
        bad_access <= 1'b1;
    end
  end

  // RAM has no reset; its contents become defined only through the clear sweep.
  always_ff @(posedge clk) begin
    if (ram_we)
      ram[ram_waddr] <= ram_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  logic       clk;
  logic       reset;
  logic       busy;
  logic       bad_access;
  logic [7:0] SW;
  logic [7:0] LEDR;

  mem_responder_if bus ();

  mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .bad_access (bad_access),
    .SW         (SW),
    .LEDR       (LEDR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // All driving and sampling happens on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
    bus.mem_cmd    = cmd;
    bus.mem_addr   = addr;
    bus.write_data = data;
  endtask

  // Counts sampled cycles with busy high starting at the current falling edge,
  // bounded so a stuck busy cannot hang the run.
  task automatic count_busy(output int cnt, output logic rv_seen);
    cnt = 0;
    rv_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      cnt++;
      if (bus.read_valid) rv_seen = 1'b1;
      tick();
    end
  endtask

  int   cnt;
  logic rv;

  initial begin
    reset = 1'b1;
    SW    = 8'h00;
    drive(2'b01, 9'h1FF, 16'h0000);
    tick();

    // Reset state
    chk("rst_read_data",  bus.read_data, 16'h0000);
    chk("rst_read_valid", {15'b0, bus.read_valid}, 16'h0000);
    chk("rst_ledr",       {8'h00, LEDR}, 16'h0000);
    chk("rst_bad_access", {15'b0, bad_access}, 16'h0000);
    chk("rst_busy",       {15'b0, busy}, 16'h0001);

    // Clear sweep with READ held to an unmapped address: all ignored
    reset = 1'b0;
    count_busy(cnt, rv);
    chk("clear_len",       cnt[15:0], 16'd256);
    chk("clear_no_rv",     {15'b0, rv}, 16'h0000);
    chk("clear_no_bad",    {15'b0, bad_access}, 16'h0000);

    drive(2'b01, 9'h0FF, 16'h0000); tick();
    chk("rd_0ff_data",  bus.read_data, 16'h0000);
    chk("rd_0ff_valid", {15'b0, bus.read_valid}, 16'h0001);

    // Write then read next cycle
    drive(2'b10, 9'h012, 16'hBEEF); tick();
    chk("wr_no_valid",  {15'b0, bus.read_valid}, 16'h0000);
    drive(2'b01, 9'h012, 16'h0000); tick();
    chk("rd_012_data",  bus.read_data, 16'hBEEF);
    chk("rd_012_valid", {15'b0, bus.read_valid}, 16'h0001);
    drive(2'b00, 9'h000, 16'h5555); tick();
    chk("none_valid",   {15'b0, bus.read_valid}, 16'h0000);
    chk("none_hold",    bus.read_data, 16'hBEEF);
    drive(2'b10, 9'h000, 16'h7777); tick();
    chk("wr_hold",      bus.read_data, 16'hBEEF);

    // Back-to-back reads
    drive(2'b10, 9'h001, 16'h1111); tick();
    drive(2'b10, 9'h002, 16'h2222); tick();
    drive(2'b10, 9'h003, 16'h3333); tick();
    drive(2'b01, 9'h001, 16'h0000); tick();
    chk("b2b_1_data", bus.read_data, 16'h1111);
    chk("b2b_1_vld",  {15'b0, bus.read_valid}, 16'h0001);
    drive(2'b01, 9'h002, 16'h0000); tick();
    chk("b2b_2_data", bus.read_data, 16'h2222);
    chk("b2b_2_vld",  {15'b0, bus.read_valid}, 16'h0001);
    drive(2'b01, 9'h003, 16'h0000); tick();
    chk("b2b_3_data", bus.read_data, 16'h3333);
    chk("b2b_3_vld",  {15'b0, bus.read_valid}, 16'h0001);
    drive(2'b00, 9'h000, 16'h0000); tick();
    chk("b2b_end_vld", {15'b0, bus.read_valid}, 16'h0000);

    // Switch and LED I/O
    SW = 8'hA5;
    tick(); tick(); tick();
    drive(2'b01, 9'h140, 16'h0000); tick();
    chk("rd_sw",      bus.read_data, 16'h00A5);
    drive(2'b10, 9'h100, 16'h1234); tick();
    chk("ledr_wr",    {8'h00, LEDR}, 16'h0034);
    drive(2'b01, 9'h100, 16'h0000); tick();
    chk("rd_led",     bus.read_data, 16'h0034);
    chk("no_bad_yet", {15'b0, bad_access}, 16'h0000);

    // Write to read-only switch port
    drive(2'b10, 9'h140, 16'hFFFF); tick();
    chk("wr_sw_bad",  {15'b0, bad_access}, 16'h0001);
    chk("wr_sw_led",  {8'h00, LEDR}, 16'h0034);
    drive(2'b01, 9'h140, 16'h0000); tick();
    chk("rd_sw_after", bus.read_data, 16'h00A5);
    drive(2'b00, 9'h000, 16'h0000); tick();
    chk("bad_sticky", {15'b0, bad_access}, 16'h0001);

    // Reset with LEDR=0x34: outputs clear asynchronously
    #2 reset = 1'b1;
    #1;
    chk("arst_ledr", {8'h00, LEDR}, 16'h0000);
    chk("arst_bad",  {15'b0, bad_access}, 16'h0000);
    chk("arst_busy", {15'b0, busy}, 16'h0001);
    chk("arst_rdat", bus.read_data, 16'h0000);
    tick();
    reset = 1'b0;
    drive(2'b11, 9'h000, 16'h0000);
    count_busy(cnt, rv);
    chk("clear2_len", cnt[15:0], 16'd256);
    chk("clear2_bad", {15'b0, bad_access}, 16'h0000);

    // Unmapped read
    drive(2'b01, 9'h1FF, 16'h0000); tick();
    chk("rd_unmap_data", bus.read_data, 16'h0000);
    chk("rd_unmap_vld",  {15'b0, bus.read_valid}, 16'h0001);
    chk("rd_unmap_bad",  {15'b0, bad_access}, 16'h0001);

    // Reset 100 cycles into clear: sweep restarts in full
    drive(2'b00, 9'h000, 16'h0000);
    reset = 1'b1; tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_busy", {15'b0, busy}, 16'h0001);
    #2 reset = 1'b1;
    #1;
    chk("mid_bad", {15'b0, bad_access}, 16'h0000);
    tick();
    reset = 1'b0;
    count_busy(cnt, rv);
    chk("clear3_len", cnt[15:0], 16'd256);

    // RAM was zeroed by the sweep
    drive(2'b01, 9'h012, 16'h0000); tick();
    chk("rd_cleared", bus.read_data, 16'h0000);

    // Reserved command
    drive(2'b11, 9'h012, 16'hAAAA); tick();
    chk("rsvd_bad", {15'b0, bad_access}, 16'h0001);
    chk("rsvd_vld", {15'b0, bus.read_valid}, 16'h0000);
    drive(2'b01, 9'h012, 16'h0000); tick();
    chk("rsvd_nowr", bus.read_data, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
